// File: rtl/prog_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : prog_sequence_generator
// Purpose  : Table-driven WIDTH-bit sequence source with loop, one-shot and
//            ping-pong playback over a programmable length.
// Revision : 1.0 - initial release
// ============================================================================
module prog_sequence_generator #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] cfg_last,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_wdata,
    output logic [WIDTH-1:0]  data,
    output logic              valid,
    output logic [ADDR_W-1:0] index,
    output logic              wrap,
    output logic              done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_mode_loop     = 2'b00;
    localparam logic [1:0] c_mode_oneshot  = 2'b01;
    localparam logic [1:0] c_mode_pingpong = 2'b10;

    localparam logic [ADDR_W:0]   c_depth    = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] c_last_max = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  r_table [DEPTH];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [WIDTH-1:0]  r_data;
    logic              r_valid;
    logic              r_wrap;
    logic              r_done;
    logic              r_dir_down;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_last;

    logic [ADDR_W-1:0] w_next_ptr;
    logic              w_next_dir;
    logic              w_step_wrap;
    logic              w_finish;
    logic [ADDR_W-1:0] w_start_last;
    logic              w_we_ok;

    assign w_start_last = ({1'b0, cfg_last} > {1'b0, c_last_max}) ? c_last_max : cfg_last;
    assign w_we_ok      = cfg_we && ({1'b0, cfg_addr} < c_depth);

    // Successor of r_ptr for one enabled step in the latched mode.
    always_comb begin
        w_next_ptr  = r_ptr;
        w_next_dir  = r_dir_down;
        w_step_wrap = 1'b0;
        w_finish    = 1'b0;
        case (r_mode)
            c_mode_oneshot: begin
                if (r_ptr == r_last) w_finish = 1'b1;
                else                 w_next_ptr = r_ptr + 1'b1;
            end
            c_mode_pingpong: begin
                if (r_last == '0) begin
                    w_next_ptr = '0;
                end else if (!r_dir_down && (r_ptr != r_last)) begin
                    w_next_ptr = r_ptr + 1'b1;
                end else begin
                    w_next_ptr = r_ptr - 1'b1;
                    w_next_dir = 1'b1;
                end
                if (w_next_ptr == '0) begin
                    w_step_wrap = 1'b1;
                    w_next_dir  = 1'b0;
                end
            end
            default: begin
                if (r_ptr == r_last) begin
                    w_next_ptr  = '0;
                    w_step_wrap = 1'b1;
                end else begin
                    w_next_ptr = r_ptr + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
            r_state    <= c_st_idle;
            r_ptr      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_dir_down <= 1'b0;
            r_mode     <= c_mode_loop;
            r_last     <= c_last_max;
        end else begin
            if (w_we_ok) r_table[cfg_addr] <= cfg_wdata;

            // Table read uses the pre-write contents, so a same-cycle write is not seen.
            if (start) begin
                r_state    <= c_st_run;
                r_ptr      <= '0;
                r_data     <= r_table[0];
                r_valid    <= 1'b1;
                r_wrap     <= 1'b0;
                r_done     <= 1'b0;
                r_dir_down <= 1'b0;
                r_mode     <= mode;
                r_last     <= w_start_last;
            end else if (r_state == c_st_run && enable) begin
                if (w_finish) begin
                    r_state <= c_st_done;
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                    r_wrap  <= 1'b0;
                end else begin
                    r_ptr      <= w_next_ptr;
                    r_data     <= r_table[w_next_ptr];
                    r_dir_down <= w_next_dir;
                    r_wrap     <= w_step_wrap;
                end
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign index = r_ptr;
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule
`default_nettype wire
